morse_shifter: RTL and testbench
================================

// Module: morse_shifter
// PURPOSE
//  Serialises one 12-bit Morse pattern from the letter-select mux onto a
//  single LED. A start pulse captures the pattern; the block then emits it
//  MSB-first, one bit per display tick. A tick is TICK_DIV clocks, which is
//  0.5 s at 50 MHz by default. The block sits directly downstream of the
//  8:1 pattern mux and drives the board LED.
// PARAMETERS
//  PATTERN_W  12          width of pattern, i.e. number of bits shown per letter
//  TICK_DIV   25_000_000  clocks per displayed bit; must be >= 2
// PORTS
//  clock    in   1          system clock; all state changes on rising edge
//  resetn   in   1          synchronous reset, active-low
//  start    in   1          level input (e.g. debounced KEY); its rising edge requests a send
//  pattern  in   PATTERN_W  Morse pattern from the mux; sampled only at capture
//  led      out  1          serial Morse output
//  busy     out  1          high while a pattern is being shown
//  done     out  1          single-cycle pulse when a send completes
// BEHAVIOUR
//  - Reset (resetn=0 at an edge):
//    - state=IDLE; shift reg, tick counter, bit counter and start_q all = 0.
//    - led=0, busy=0, done=0 in the following cycle.
//    - Reset wins over every other event, including mid-send.
//  - Edge detect: rise = start & ~start_q; start_q <= start every cycle.
//    - start_q resets to 0, so start held high across reset release
//      gives a rise on the first cycle out of reset.
//  - States: IDLE, SHIFT.
//  - IDLE, with rise at edge N:
//    - shreg <= pattern, tick_cnt <= 0, bit_cnt <= 0, state <= SHIFT.
//    - busy=1 from cycle N+1.
//  - IDLE without rise: all state holds; led=0.
//  - SHIFT, each edge:
//    - If tick_cnt == TICK_DIV-1: tick_cnt <= 0, shreg <= shreg<<1
//      (zero fill), bit_cnt <= bit_cnt+1.
//    - Otherwise tick_cnt <= tick_cnt+1.
//  - SHIFT exit: when a tick occurs with bit_cnt == PATTERN_W-1,
//    state <= IDLE and done <= 1 for exactly the next cycle.
//  - led = busy & shreg[PATTERN_W-1], combinational from registers, so the
//    LED has no extra latency.
//  - Timing: each pattern bit is shown for exactly TICK_DIV cycles.
//    - busy is high for exactly PATTERN_W*TICK_DIV cycles.
//    - done coincides with the first IDLE cycle (busy=0).
//  - Rises during SHIFT are ignored and are not queued.
//  - A rise in the same cycle done=1 is accepted, since state is IDLE.
//  - pattern changes after capture have no effect on the send in progress.
//  - Widths:
//    - tick_cnt is $clog2(TICK_DIV) bits and wraps only via the explicit
//      compare, never by overflow.
//    - bit_cnt is $clog2(PATTERN_W+1) bits.
//  - An all-zero pattern is still a full-length send: busy for
//    PATTERN_W*TICK_DIV cycles, led stays 0, then done.
// TESTING  (TICK_DIV=4, PATTERN_W=12)
//  1. pattern=12'b1011_1000_0000, start 0->1 at edge N -> led=1 for cycles N+1..N+4,
//     0 for N+5..N+8, 1 for N+9..N+20, then 0; busy=1 for N+1..N+48;
//     done=1 only at N+49.
//  2. Hold start high and pulse it again at N+10 -> ignored; send timing
//     identical to case 1; no second send.
//  3. Change pattern to 12'hFFF at N+3 -> led sequence still matches case 1.
//  4. resetn=0 at N+20 mid-send -> at N+21 led=0, busy=0, done=0; a new start
//     after reset release sends a full fresh pattern.
//  5. start low during the send, rising exactly in the done cycle -> new
//     capture accepted; busy re-asserts the next cycle.
//  6. pattern=0 -> led stays 0 throughout; busy=1 for 48 cycles; done pulses once.

Source files
------------

// File: rtl/morse_shifter.sv
// Morse pattern serialiser: a rising edge on start captures a PATTERN_W-bit
// pattern, which is then shown MSB-first on led, one bit per TICK_DIV clocks.
module morse_shifter #(
    parameter int PATTERN_W = 12,
    parameter int TICK_DIV  = 25_000_000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    output logic                 led,
    output logic                 busy,
    output logic                 done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BIT_W  = $clog2(PATTERN_W + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PATTERN_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state, state_next;
    logic [PATTERN_W-1:0] shreg, shreg_next;
    logic [TICK_W-1:0]    tick_cnt, tick_cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 start_q;
    logic                 done_next;
    logic                 rise;
    logic                 tick;

    assign rise = start & ~start_q;
    assign tick = (tick_cnt == TICK_LAST);

    // NOTE: every next-value signal takes a hold default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        tick_cnt_next = tick_cnt;
        bit_cnt_next  = bit_cnt;
        done_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (rise) begin
                    shreg_next    = pattern;
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    tick_cnt_next = '0;
                    shreg_next    = shreg << 1;
                    bit_cnt_next  = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    tick_cnt_next = tick_cnt + TICK_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            shreg    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            start_q  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            tick_cnt <= tick_cnt_next;
            bit_cnt  <= bit_cnt_next;
            start_q  <= start;
            done     <= done_next;
        end
    end

    // LED follows the register MSB directly, so there is no added latency.
    assign busy = (state == SHIFT);
    assign led  = busy & shreg[PATTERN_W-1];

endmodule

// File: tb/tb_morse_shifter.sv
// Directed bench for morse_shifter with TICK_DIV=4, PATTERN_W=12: timing of
// led/busy/done, ignored re-triggers, pattern isolation, reset and restart.
module tb_morse_shifter;

    localparam int PW = 12;
    localparam int TD = 4;
    localparam int SEND_CYCLES = PW * TD;

    logic          clock = 1'b0;
    logic          resetn;
    logic          start;
    logic [PW-1:0] pattern;
    logic          led;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    morse_shifter #(.PATTERN_W(PW), .TICK_DIV(TD)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .pattern (pattern),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Expected led in cycle N+k for a send captured at edge N.
    function automatic logic exp_led(input logic [PW-1:0] pat, input int k);
        if (k < 1 || k > SEND_CYCLES) return 1'b0;
        return pat[PW-1 - (k-1)/TD];
    endfunction

    task automatic test_reset();
        resetn  = 1'b0;
        start   = 1'b0;
        pattern = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({led, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got led/busy/done=%b want 000", {led, busy, done});
        end
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({led, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: got led/busy/done=%b want 000", {led, busy, done});
        end
    endtask

    // Runs one send and checks every cycle N+1..N+49. Optional disturbances:
    // a start re-pulse at N+pulse_at, a pattern change to FFF at N+change_at,
    // or dropping start after capture and re-raising it in the done cycle.
    task automatic run_send(input string name, input logic [PW-1:0] pat,
                            input int pulse_at, input int change_at,
                            input bit rise_in_done);
        int done_count;
        done_count = 0;
        @(negedge clock);
        start   = 1'b0;
        pattern = pat;
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= SEND_CYCLES + 1; k++) begin
            @(negedge clock);
            total++;
            if (led !== exp_led(pat, k)) begin
                bad++;
                $display("FAIL %s led k=%0d: got %b want %b", name, k, led, exp_led(pat, k));
            end
            total++;
            if (busy !== (k <= SEND_CYCLES)) begin
                bad++;
                $display("FAIL %s busy k=%0d: got %b want %b", name, k, busy, (k <= SEND_CYCLES));
            end
            total++;
            if (done !== (k == SEND_CYCLES + 1)) begin
                bad++;
                $display("FAIL %s done k=%0d: got %b want %b", name, k, done, (k == SEND_CYCLES + 1));
            end
            if (pulse_at != 0 && k == pulse_at - 1) start = 1'b0;
            if (pulse_at != 0 && k == pulse_at)     start = 1'b1;
            if (change_at != 0 && k == change_at)   pattern = '1;
            if (rise_in_done && k == 1)             start = 1'b0;
            if (rise_in_done && k == SEND_CYCLES + 1) start = 1'b1;
        end
        if (rise_in_done) begin
            @(negedge clock);
            total++;
            if (busy !== 1'b1 || led !== pattern[PW-1]) begin
                bad++;
                $display("FAIL %s recapture: got busy=%b led=%b want busy=1 led=%b",
                         name, busy, led, pattern[PW-1]);
            end
            for (int i = 0; i < SEND_CYCLES + 10 && done !== 1'b1; i++) @(negedge clock);
            total++;
            if (done !== 1'b1) begin
                bad++;
                $display("FAIL %s second_done: got done=%b want 1 within budget", name, done);
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                if (busy || done) done_count++;
            end
            total++;
            if (done_count !== 0) begin
                bad++;
                $display("FAIL %s no_resend: got %0d active cycles want 0", name, done_count);
            end
        end
    endtask

    task automatic test_basic_send();
        run_send("basic", 12'b1011_1000_0000, 0, 0, 1'b0);
    endtask

    task automatic test_ignored_rise();
        run_send("ignored_rise", 12'b1011_1000_0000, 10, 0, 1'b0);
    endtask

    task automatic test_pattern_change();
        run_send("pattern_change", 12'b1011_1000_0000, 0, 3, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        @(negedge clock);
        start   = 1'b0;
        pattern = 12'b1011_1000_0000;
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) @(negedge clock);
        total++;
        if (led !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid pre: got led=%b busy=%b want 1 1", led, busy);
        end
        resetn = 1'b0;
        @(negedge clock);
        total++;
        if ({led, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid post: got led/busy/done=%b want 000", {led, busy, done});
        end
        // start is still high here, so release alone must produce a rise.
        pattern = 12'hA5A;
        resetn  = 1'b1;
        @(negedge clock);
        total++;
        if (busy !== 1'b1 || led !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_rise: got busy=%b led=%b want 1 1", busy, led);
        end
        for (int i = 0; i < SEND_CYCLES + 10 && done !== 1'b1; i++) @(negedge clock);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_done: got done=%b want 1 within budget", done);
        end
        run_send("fresh_after_reset", 12'b1100_0011_0101, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_send("rise_in_done", 12'b1001_0110_1111, 0, 0, 1'b1);
    endtask

    task automatic test_zero_pattern();
        run_send("zero_pattern", 12'h000, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_send();
        test_ignored_rise();
        test_pattern_change();
        test_reset_mid_send();
        test_back_to_back();
        test_zero_pattern();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
